// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: one bit per cycle (shift-add multiply, restoring divide)
// with sign handling around an unsigned core. Results land in HI/LO on completion.
module muldiv_sequencer #(
    parameter int unsigned IO_BUS_WIDTH = 32,
    parameter int unsigned OP_BUS_WIDTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [OP_BUS_WIDTH-1:0] i_op,
    input  logic [IO_BUS_WIDTH-1:0] i_data_a,
    input  logic [IO_BUS_WIDTH-1:0] i_data_b,
    input  logic                    i_flush,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [IO_BUS_WIDTH-1:0] o_hi,
    output logic [IO_BUS_WIDTH-1:0] o_lo,
    output logic                    o_div_zero
);

    localparam int unsigned N  = IO_BUS_WIDTH;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic [OP_BUS_WIDTH-1:0] op_q;
    logic [N-1:0]            a_q;
    logic [N-1:0]            b_q;
    logic [N-1:0]            opnd_q;
    logic [N-1:0]            hi_acc_q;
    logic [N-1:0]            lo_acc_q;
    logic [CW-1:0]           cnt_q;
    logic                    neg_lo_q;
    logic                    neg_hi_q;
    logic                    dz_acc_q;
    logic                    busy_q;
    logic                    done_q;
    logic [N-1:0]            hi_q;
    logic [N-1:0]            lo_q;
    logic                    div_zero_q;

    logic                    is_div;
    logic                    is_signed;
    logic [N-1:0]            mag_a;
    logic [N-1:0]            mag_b;
    logic [N:0]              mul_sum;
    logic [N:0]              div_shift;
    logic [N-1:0]            div_diff;
    logic                    div_ge;
    logic [2*N-1:0]          prod;
    logic [2*N-1:0]          prod_neg;
    logic [N-1:0]            iter_hi_d;
    logic [N-1:0]            iter_lo_d;
    logic [N-1:0]            fix_hi_d;
    logic [N-1:0]            fix_lo_d;

    // op[1] selects divide, op[0] selects unsigned
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];

    assign mag_a = (is_signed && a_q[N-1]) ? N'(-a_q) : a_q;
    assign mag_b = (is_signed && b_q[N-1]) ? N'(-b_q) : b_q;

    assign mul_sum   = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, opnd_q} : (N+1)'(0));
    assign div_shift = {hi_acc_q, lo_acc_q[N-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    // Remainder is below the divisor whenever div_ge holds, so N bits suffice
    assign div_diff  = div_shift[N-1:0] - opnd_q;

    assign prod     = {hi_acc_q, lo_acc_q};
    assign prod_neg = (2*N)'(-prod);

    // One iteration step of the unsigned core
    always_comb begin
        iter_hi_d = mul_sum[N:1];
        iter_lo_d = {mul_sum[0], lo_acc_q[N-1:1]};
        if (is_div) begin
            iter_hi_d = div_ge ? div_diff : div_shift[N-1:0];
            iter_lo_d = {lo_acc_q[N-2:0], div_ge};
        end
    end

    // Sign restoration for the signed operations
    always_comb begin
        fix_hi_d = hi_acc_q;
        fix_lo_d = lo_acc_q;
        if (is_signed) begin
            if (is_div) begin
                if (neg_lo_q) fix_lo_d = N'(-lo_acc_q);
                if (neg_hi_q) fix_hi_d = N'(-hi_acc_q);
            end else if (neg_lo_q) begin
                {fix_hi_d, fix_lo_d} = prod_neg;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            hi_acc_q   <= '0;
            lo_acc_q   <= '0;
            cnt_q      <= '0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_acc_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_flush && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_start && !i_flush) begin
                            op_q    <= i_op;
                            a_q     <= i_data_a;
                            b_q     <= i_data_b;
                            busy_q  <= 1'b1;
                            state_q <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        if (is_div && b_q == '0) begin
                            hi_acc_q <= a_q;
                            lo_acc_q <= '1;
                            dz_acc_q <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            hi_acc_q <= '0;
                            lo_acc_q <= is_div ? mag_a : mag_b;
                            opnd_q   <= is_div ? mag_b : mag_a;
                            neg_lo_q <= is_signed & (a_q[N-1] ^ b_q[N-1]);
                            neg_hi_q <= is_signed & a_q[N-1];
                            dz_acc_q <= 1'b0;
                            cnt_q    <= CW'(N);
                            state_q  <= S_ITER;
                        end
                    end
                    S_ITER: begin
                        hi_acc_q <= iter_hi_d;
                        lo_acc_q <= iter_lo_d;
                        cnt_q    <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        hi_acc_q <= fix_hi_d;
                        lo_acc_q <= fix_lo_d;
                        state_q  <= S_DONE;
                    end
                    S_DONE: begin
                        hi_q       <= hi_acc_q;
                        lo_q       <= lo_acc_q;
                        div_zero_q <= dz_acc_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;
    assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, arithmetic results, divide-by-zero,
// busy-start rejection, flush and mid-operation reset.
module tb_muldiv_sequencer;

    localparam int unsigned N = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] da;
    logic [N-1:0] db;
    logic         flush;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_sequencer #(.IO_BUS_WIDTH(N), .OP_BUS_WIDTH(2)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_start    (start),
        .i_op       (op),
        .i_data_a   (da),
        .i_data_b   (db),
        .i_flush    (flush),
        .o_busy     (busy),
        .o_done     (done),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_div_zero (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one start at the next edge; return with cycles = 0 just after that edge
    task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        da    = a;
        db    = b;
        @(negedge clk);
        start = 1'b0;
        da    = '0;
        db    = '0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [N-1:0] a,
                          input logic [N-1:0] b, input int exp_lat, input logic [N-1:0] exp_hi,
                          input logic [N-1:0] exp_lo, input logic exp_dz);
        int cyc;
        bit seen;
        issue(o, a, b);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        check({tag, ".dz"}, 64'(dz), 64'(exp_dz));
        @(negedge clk);
        check({tag, ".done_pulse_len"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        da    = '0;
        db    = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.hi", 64'(hi), 64'd0);
        check("rst.lo", 64'(lo), 64'd0);
        check("rst.dz", 64'(dz), 64'd0);
        rst_n = 1'b1;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m7x3", OP_MULT, 32'hFFFF_FFF9, 32'd3, 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 35, 32'd2, 32'd14, 1'b0);
        run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 2, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("multu_2x3", OP_MULTU, 32'd2, 32'd3, 35, 32'd0, 32'd6, 1'b0);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'd0, 32'h8000_0000, 1'b0);
        run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 35, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("mult_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 35, 32'h4000_0000, 32'd0, 1'b0);
        run_op("div_m5d0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op("mult_12xm5", OP_MULT, 32'd12, 32'hFFFF_FFFB, 35, 32'hFFFF_FFFF, 32'hFFFF_FFC4, 1'b0);

        // Start pulse while busy must be ignored: one completion carrying 4*5
        issue(OP_MULTU, 32'd4, 32'd5);
        ndone = 0;
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (cyc == 10) begin
                start = 1'b1; op = OP_MULTU; da = 32'd9; db = 32'd9;
            end
            if (cyc == 11) begin
                start = 1'b0; da = '0; db = '0;
            end
            @(negedge clk);
            if (cyc == 10) check("ign.busy_mid", 64'(busy), 64'd1);
            if (cyc == 20) check("ign.lo_held", 64'(lo), 64'hFFFF_FFC4);
            if (done) ndone++;
        end
        check("ign.ndone", 64'(ndone), 64'd1);
        check("ign.hi", 64'(hi), 64'd0);
        check("ign.lo", 64'(lo), 64'd20);

        // Flush mid-operation: back to idle, no completion, results kept
        issue(OP_DIVU, 32'd1000, 32'd3);
        ndone = 0;
        for (cyc = 1; cyc <= 50; cyc++) begin
            if (cyc == 20) flush = 1'b1;
            if (cyc == 21) flush = 1'b0;
            @(negedge clk);
            if (cyc == 21) check("flush.busy", 64'(busy), 64'd0);
            if (done) ndone++;
        end
        check("flush.ndone", 64'(ndone), 64'd0);
        check("flush.hi", 64'(hi), 64'd0);
        check("flush.lo", 64'(lo), 64'd20);

        // Start and flush together in idle: flush wins
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OP_MULTU; da = 32'd3; db = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("sf.busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("sf.lo", 64'(lo), 64'd20);

        // Reset during a divide
        issue(OP_DIV, 32'd1000, 32'd7);
        ndone = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            if (cyc == 15) rst_n = 1'b0;
            if (cyc == 16) rst_n = 1'b1;
            @(negedge clk);
            if (cyc == 15) begin
                check("rmid.busy", 64'(busy), 64'd0);
                check("rmid.hi", 64'(hi), 64'd0);
                check("rmid.lo", 64'(lo), 64'd0);
                check("rmid.dz", 64'(dz), 64'd0);
            end
            if (done) ndone++;
        end
        check("rmid.ndone", 64'(ndone), 64'd0);
        run_op("post_rst_5x6", OP_MULTU, 32'd5, 32'd6, 35, 32'd0, 32'd30, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
